// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: state codes,
// opcodes and the PCSource/ALUSrcB/OpALU field values. The ALU decoder
// imports the same package so both ends agree on OpALU meanings.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // OpALU to the ALU decoder; 2'b11 is never produced.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] op_alu;
    } ctrl_t;

    // States whose exit to FETCH completes (retires) an instruction.
    function automatic logic is_retire_state(input state_t s);
        return (s == MEMWB) || (s == MEMWR) || (s == ALUWB) ||
               (s == BRANCH) || (s == JUMP) || (s == ADDIWB);
    endfunction

endpackage

// File: rtl/mips_control_fsm_if.sv
// Signal bundle between the control FSM and the multicycle datapath.
// Memory handshake: the FSM holds MemRead (FETCH/MEMRD) or MemWrite (MEMWR)
// and the address select steady until a cycle with mem_ready=1; that cycle
// completes the access and the FSM leaves the state on the next rising edge.
interface mips_control_fsm_if;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;

    logic        PCWrite;
    logic        PCWriteCond;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        IRWrite;
    logic        ALUSrcA;
    logic        RegWrite;
    logic        RegDst;
    logic [1:0]  PCSource;
    logic [1:0]  ALUSrcB;
    logic [1:0]  OpALU;

    logic [3:0]  state;
    logic        illegal_op;
    logic [31:0] instr_count;

    // Control FSM side. The zero flag is consumed by the datapath together
    // with PCWriteCond, so the FSM itself does not look at it.
    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
        output IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, OpALU,
        output state, illegal_op, instr_count
    );

    // Datapath side.
    modport slave (
        output opcode, zero, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
        input  IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, OpALU,
        input  state, illegal_op, instr_count
    );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Pure combinational map from the current state (plus memory ready in the
// FETCH state) to the datapath control word. Anything a state does not set
// stays 0.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  state_t state,
    input  logic   rdy,
    output ctrl_t  ctrl
);

    // Per-state control word, all-zero default first.
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.op_alu    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = rdy;
                ctrl.pc_write  = rdy;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.op_alu    = ALUOP_ADD;
            end
            MEMADR, ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.op_alu    = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.op_alu    = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.op_alu        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS main control FSM. Moore-style outputs from the state
// register (FETCH's IRWrite/PCWrite also follow mem_ready), a retired
// instruction counter, and an illegal-opcode pulse from DECODE.
// CNT_W narrows the internal counter (zero-extended onto instr_count) so
// wrap-around can be exercised without 2^32 retirements; default is 32.
module mips_control_fsm
    import mips_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_control_fsm_if.master  bus
);

    state_t             state_q;
    state_t             state_d;
    logic               rdy;
    logic               illegal;
    logic               retire;
    logic [CNT_W-1:0]   count_q;
    ctrl_t              ctrl;

    assign rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

    // State register; reset drops straight back to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, illegal-opcode flag and retire strobe.
    always_comb begin
        state_d = FETCH;
        illegal = 1'b0;
        case (state_q)
            FETCH:  state_d = rdy ? DECODE : FETCH;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDIEX;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: state_d = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_d = rdy ? MEMWB : MEMRD;
            MEMWB:  state_d = FETCH;
            MEMWR:  state_d = rdy ? FETCH : MEMWR;
            EXEC:   state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            JUMP:   state_d = FETCH;
            ADDIEX: state_d = ADDIWB;
            ADDIWB: state_d = FETCH;
            default: state_d = FETCH;
        endcase
        retire = is_retire_state(state_q) && (state_d == FETCH);
    end

    // Retired-instruction counter; wraps naturally at full scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    mips_ctrl_decode u_decode (
        .state (state_q),
        .rdy   (rdy),
        .ctrl  (ctrl)
    );

    // While reset is low, every write/strobe control is held off; the
    // select fields keep their FETCH values from the decoder.
    assign bus.PCWrite     = rst_n & ctrl.pc_write;
    assign bus.PCWriteCond = rst_n & ctrl.pc_write_cond;
    assign bus.MemRead     = rst_n & ctrl.mem_read;
    assign bus.MemWrite    = rst_n & ctrl.mem_write;
    assign bus.IRWrite     = rst_n & ctrl.ir_write;
    assign bus.RegWrite    = rst_n & ctrl.reg_write;
    assign bus.IorD        = ctrl.ior_d;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.OpALU       = ctrl.op_alu;

    assign bus.state       = state_q;
    assign bus.illegal_op  = rst_n & illegal;
    assign bus.instr_count = 32'(count_q);

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for mips_control_fsm: instruction walks with hand-derived
// state/control sequences, memory stalls, illegal opcode, mid-instruction
// reset, and counter wrap on a narrow-counter instance.
module tb_mips_control_fsm;

    // Control word order:
    // PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite ALUSrcA
    // RegWrite RegDst PCSource[1:0] ALUSrcB[1:0] OpALU[1:0]
    localparam logic [15:0] C_FETCH_RDY  = 16'b1001_0010_0000_0100;
    localparam logic [15:0] C_FETCH_WAIT = 16'b0001_0000_0000_0100;
    localparam logic [15:0] C_RESET      = 16'b0000_0000_0000_0100;
    localparam logic [15:0] C_DECODE     = 16'b0000_0000_0000_1100;
    localparam logic [15:0] C_MEMADR     = 16'b0000_0001_0000_1000;
    localparam logic [15:0] C_MEMRD      = 16'b0011_0000_0000_0000;
    localparam logic [15:0] C_MEMWB      = 16'b0000_0100_1000_0000;
    localparam logic [15:0] C_MEMWR      = 16'b0010_1000_0000_0000;
    localparam logic [15:0] C_EXEC       = 16'b0000_0001_0000_0010;
    localparam logic [15:0] C_ALUWB      = 16'b0000_0000_1100_0000;
    localparam logic [15:0] C_BRANCH     = 16'b0100_0001_0001_0001;
    localparam logic [15:0] C_JUMP       = 16'b1000_0000_0010_0000;
    localparam logic [15:0] C_ADDIEX     = 16'b0000_0001_0000_1000;
    localparam logic [15:0] C_ADDIWB     = 16'b0000_0000_1000_0000;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic rst2_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    mips_control_fsm_if bus ();
    mips_control_fsm_if bus2 ();

    mips_control_fsm #(.MEM_WAIT_EN(1'b1), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Narrow counter and no memory waiting: wrap and MEM_WAIT_EN=0 checks.
    mips_control_fsm #(.MEM_WAIT_EN(1'b0), .CNT_W(4)) dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    logic [15:0] ctl;
    logic [15:0] ctl2;
    assign ctl  = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                   bus.MemWrite, bus.MemtoReg, bus.IRWrite, bus.ALUSrcA,
                   bus.RegWrite, bus.RegDst, bus.PCSource, bus.ALUSrcB,
                   bus.OpALU};
    assign ctl2 = {bus2.PCWrite, bus2.PCWriteCond, bus2.IorD, bus2.MemRead,
                   bus2.MemWrite, bus2.MemtoReg, bus2.IRWrite, bus2.ALUSrcA,
                   bus2.RegWrite, bus2.RegDst, bus2.PCSource, bus2.ALUSrcB,
                   bus2.OpALU};

    // ---------------- scoring ----------------
    int total_cnt;
    int pass_cnt;
    int fail_cnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already set: checks the current
    // cycle of dut, then advances to the next falling edge.
    task automatic cyc(input string tag, input logic [3:0] st,
                       input logic [15:0] c, input logic ill,
                       input logic [31:0] cnt);
        #1;
        chk({tag, ".state"}, 32'(bus.state), 32'(st));
        chk({tag, ".ctrl"},  32'(ctl), 32'(c));
        chk({tag, ".ill"},   32'(bus.illegal_op), 32'(ill));
        chk({tag, ".count"}, bus.instr_count, cnt);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        fail_cnt  = 0;
        bus.opcode     = 6'b000000;
        bus.zero       = 1'b0;
        bus.mem_ready  = 1'b1;
        bus2.opcode    = 6'b000010;
        bus2.zero      = 1'b0;
        bus2.mem_ready = 1'b0;
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        #1;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        #2;
        chk("rst.state", 32'(bus.state), 32'd0);
        chk("rst.ctrl",  32'(ctl), 32'(C_RESET));
        chk("rst.ill",   32'(bus.illegal_op), 32'd0);
        chk("rst.count", bus.instr_count, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // R-type
        bus.opcode = 6'b000000;
        cyc("r.fetch",  4'd0, C_FETCH_RDY, 1'b0, 32'd0);
        cyc("r.decode", 4'd1, C_DECODE,    1'b0, 32'd0);
        cyc("r.exec",   4'd6, C_EXEC,      1'b0, 32'd0);
        cyc("r.aluwb",  4'd7, C_ALUWB,     1'b0, 32'd0);

        // LW with a fetch stall and three wait cycles in MEMRD
        bus.opcode    = 6'b100011;
        bus.mem_ready = 1'b0;
        cyc("lw.fwait", 4'd0, C_FETCH_WAIT, 1'b0, 32'd1);
        bus.mem_ready = 1'b1;
        cyc("lw.fetch",  4'd0, C_FETCH_RDY, 1'b0, 32'd1);
        cyc("lw.decode", 4'd1, C_DECODE,    1'b0, 32'd1);
        cyc("lw.memadr", 4'd2, C_MEMADR,    1'b0, 32'd1);
        bus.mem_ready = 1'b0;
        cyc("lw.rdw0",   4'd3, C_MEMRD,     1'b0, 32'd1);
        cyc("lw.rdw1",   4'd3, C_MEMRD,     1'b0, 32'd1);
        cyc("lw.rdw2",   4'd3, C_MEMRD,     1'b0, 32'd1);
        bus.mem_ready = 1'b1;
        cyc("lw.memrd",  4'd3, C_MEMRD,     1'b0, 32'd1);
        cyc("lw.memwb",  4'd4, C_MEMWB,     1'b0, 32'd1);

        // SW with one wait cycle in MEMWR
        bus.opcode = 6'b101011;
        cyc("sw.fetch",  4'd0, C_FETCH_RDY, 1'b0, 32'd2);
        cyc("sw.decode", 4'd1, C_DECODE,    1'b0, 32'd2);
        cyc("sw.memadr", 4'd2, C_MEMADR,    1'b0, 32'd2);
        bus.mem_ready = 1'b0;
        cyc("sw.wrw",    4'd5, C_MEMWR,     1'b0, 32'd2);
        bus.mem_ready = 1'b1;
        cyc("sw.memwr",  4'd5, C_MEMWR,     1'b0, 32'd2);

        // BEQ taken
        bus.opcode = 6'b000100;
        bus.zero   = 1'b1;
        cyc("beq.fetch",  4'd0, C_FETCH_RDY, 1'b0, 32'd3);
        cyc("beq.decode", 4'd1, C_DECODE,    1'b0, 32'd3);
        cyc("beq.branch", 4'd8, C_BRANCH,    1'b0, 32'd3);
        bus.zero   = 1'b0;

        // ADDI
        bus.opcode = 6'b001000;
        cyc("addi.fetch",  4'd0,  C_FETCH_RDY, 1'b0, 32'd4);
        cyc("addi.decode", 4'd1,  C_DECODE,    1'b0, 32'd4);
        cyc("addi.ex",     4'd10, C_ADDIEX,    1'b0, 32'd4);
        cyc("addi.wb",     4'd11, C_ADDIWB,    1'b0, 32'd4);

        // Illegal opcode: back to FETCH, not counted
        bus.opcode = 6'b111111;
        cyc("ill.fetch",  4'd0, C_FETCH_RDY, 1'b0, 32'd5);
        cyc("ill.decode", 4'd1, C_DECODE,    1'b1, 32'd5);
        cyc("ill.after",  4'd0, C_FETCH_RDY, 1'b0, 32'd5);

        // Reset while waiting in MEMWR (state already advanced to DECODE)
        bus.opcode = 6'b101011;
        cyc("swr.decode", 4'd1, C_DECODE, 1'b0, 32'd5);
        cyc("swr.memadr", 4'd2, C_MEMADR, 1'b0, 32'd5);
        bus.mem_ready = 1'b0;
        cyc("swr.wrw",    4'd5, C_MEMWR,  1'b0, 32'd5);
        rst_n = 1'b0;
        #1;
        chk("mrst.state", 32'(bus.state), 32'd0);
        chk("mrst.ctrl",  32'(ctl), 32'(C_RESET));
        chk("mrst.memwr", 32'(bus.MemWrite), 32'd0);
        chk("mrst.count", bus.instr_count, 32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.mem_ready = 1'b1;

        // Jump after reset release
        bus.opcode = 6'b000010;
        cyc("j.fetch",  4'd0, C_FETCH_RDY, 1'b0, 32'd0);
        cyc("j.decode", 4'd1, C_DECODE,    1'b0, 32'd0);
        cyc("j.jump",   4'd9, C_JUMP,      1'b0, 32'd0);
        cyc("j.done",   4'd0, C_FETCH_RDY, 1'b0, 32'd1);

        // Wrap on the 4-bit counter instance, mem_ready held low
        rst2_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            #1;
            chk("wrap.fetch", 32'(bus2.state), 32'd0);
            chk("wrap.fctl",  32'(ctl2), 32'(C_FETCH_RDY));
            chk("wrap.count", bus2.instr_count, 32'(i % 16));
            @(negedge clk);
            #1;
            chk("wrap.decode", 32'(bus2.state), 32'd1);
            @(negedge clk);
            #1;
            chk("wrap.jump", 32'(bus2.state), 32'd9);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mips_control_fsm.md
MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001 Parameter MEM_WAIT_EN, default 1: when 1, FETCH/MEMRD/MEMWR hold until mem_ready; when 0, mem_ready is treated as constant 1.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  6  instr[31:26] from instruction register; sampled in DECODE.
REQ-005 zero  input  1  ALU zero flag; used in BRANCH.
REQ-006 mem_ready  input  1  memory access complete this cycle.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  standard multicycle datapath controls.
REQ-008 PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-009 ALUSrcB  output  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-010 OpALU  output  2  to ALU decoder: 00 add, 01 sub, 10 use funct; 11 never driven.
REQ-011 state  output  4  current state code, debug.
REQ-012 illegal_op  output  1  one-cycle pulse on unsupported opcode.
REQ-013 instr_count  output  32  retired-instruction counter.

Function
REQ-014 States/codes SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11; codes 12-15 SHALL transition to FETCH.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, OpALU=00, PCSource=00; IRWrite=PCWrite=mem_ready; advance to DECODE only when mem_ready=1, else stay.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, OpALU=00; next by opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> ADDIEX, other -> FETCH with illegal_op=1 that cycle.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, OpALU=00; -> MEMRD if opcode=100011, else MEMWR.
REQ-018 MEMRD: MemRead=1, IorD=1; -> MEMWB when mem_ready, else stay.
REQ-019 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; -> FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1; -> FETCH when mem_ready, else stay (MemWrite held high while waiting).
REQ-021 EXEC: ALUSrcA=1, ALUSrcB=00, OpALU=10; -> ALUWB. ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; -> FETCH.
REQ-022 BRANCH: ALUSrcA=1, ALUSrcB=00, OpALU=01, PCWriteCond=1, PCSource=01, PCWrite=0; -> FETCH regardless of zero.
REQ-023 JUMP: PCWrite=1, PCSource=10; -> FETCH.
REQ-024 ADDIEX: ALUSrcA=1, ALUSrcB=10, OpALU=00; -> ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; -> FETCH.
REQ-025 Any control not listed for a state SHALL be 0.
REQ-026 Outputs SHALL be combinational from the state register (plus mem_ready in FETCH/MEMRD/MEMWR); no added latency.
REQ-027 instr_count SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JUMP or ADDIWB; wraps 0xFFFFFFFF -> 0; illegal-opcode returns SHALL NOT count.
REQ-028 Cycle counts with mem_ready=1: R-type/ADDI/LW-minus-one = 4, LW 5, SW 4, BEQ 3, J 3.

Reset
REQ-029 rst_n low SHALL immediately set state=FETCH, instr_count=0, illegal_op=0.
REQ-030 While rst_n low, PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite SHALL be forced 0; other outputs take FETCH values.
REQ-031 Reset asserted mid-instruction SHALL abandon it without counting; first FETCH after release behaves as REQ-015.

Structure
REQ-032 State codes, opcode constants and OpALU/ALUSrcB/PCSource encodings SHALL live in shared package mips_pkg, reused by the ALU decoder.
REQ-033 Single module; optional sub-module mips_ctrl_decode (state->control outputs, combinational).

Verification
REQ-034 R-type (opcode 000000, mem_ready=1): states 0,1,6,7,0; OpALU=10 in EXEC; RegWrite=RegDst=1 in ALUWB; instr_count 0->1.
REQ-035 LW (100011) with mem_ready low 3 cycles in MEMRD: states 0,1,2,3,3,3,3,4,0; IorD=1 throughout MEMRD; count +1.
REQ-036 BEQ (000100), zero=1: states 0,1,8,0; OpALU=01, PCWriteCond=1, PCSource=01 in BRANCH.
REQ-037 Opcode 111111: DECODE -> FETCH, illegal_op pulses 1 cycle, instr_count unchanged.
REQ-038 rst_n low during MEMWR: state=0 same cycle, MemWrite=0, instr_count=0; after release J (000010) runs states 0,1,9,0 with PCSource=10.
REQ-039 Preload-free wrap: force 2^32 retirements (or test with counter width override) -> instr_count 0xFFFFFFFF -> 0x00000000.
